rgmii_transmit_framer: RTL and testbench



---
 rtl/rgmii_transmit_framer.sv | 178 +++++++++++++++++
 tb/tb_rgmii_transmit_framer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_transmit_framer.sv
// RGMII transmit framer: adds preamble/SFD, pads, appends CRC-32 FCS and
// enforces the inter-frame gap; emits one byte per clock as DDR nibble pairs.
//
// Ports:
//   clock, reset      125 MHz clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready  upstream byte stream (valid/ready)
//   ddr_data_output   [7:4] = byte[3:0] (rise), [3:0] = byte[7:4] (fall)
//   ddr_ctl_output    [1] = TX_EN (rise), [0] = TX_EN ^ TX_ER (fall)
//   frame_done        pulse with the last FCS byte
//   underrun          pulse for each starved DATA cycle
module rgmii_transmit_framer #(
    parameter int MIN_FRAME_BYTES = 60,
    parameter int ENABLE_PADDING  = 1,
    parameter int IFG_BYTES       = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] ddr_data_output,
    output logic [1:0] ddr_ctl_output,
    output logic       frame_done,
    output logic       underrun
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, SFD, DATA, PAD, FCS, GAP
    } state_t;

    localparam logic [11:0] MIN_LEN  = 12'(MIN_FRAME_BYTES);
    // The IDLE cycle after GAP supplies the final idle byte time.
    localparam logic [7:0]  GAP_LAST = 8'(IFG_BYTES - 2);
    localparam logic [10:0] CNT_MAX  = 11'h7FF;

    state_t      state_q, state_d;
    logic [7:0]  sub_q, sub_d;
    logic [10:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q, txd_d;
    logic [1:0]  ctl_q, ctl_d;
    logic        done_q, done_d;
    logic        und_q, und_d;

    logic [7:0]  byte_o;
    logic        tx_en;
    logic        tx_er;
    logic [11:0] cnt_inc;
    logic [10:0] cnt_sat;
    logic [31:0] crc_inv;

    function automatic logic [31:0] crc_next(input logic [31:0] c,
                                             input logic [7:0]  d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign s_ready = (state_q == DATA);

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        done_d  = 1'b0;
        und_d   = 1'b0;
        byte_o  = 8'h00;
        tx_en   = 1'b0;
        tx_er   = 1'b0;
        cnt_inc = {1'b0, cnt_q} + 12'd1;
        cnt_sat = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc[10:0];
        crc_inv = ~crc_q;

        unique case (state_q)
            IDLE: begin
                if (s_valid) begin
                    state_d = PREAMBLE;
                    sub_d   = 8'd0;
                end
            end
            PREAMBLE: begin
                byte_o = 8'h55;
                tx_en  = 1'b1;
                if (sub_q == 8'd6) state_d = SFD;
                else               sub_d   = sub_q + 8'd1;
            end
            SFD: begin
                byte_o  = 8'hD5;
                tx_en   = 1'b1;
                crc_d   = 32'hFFFFFFFF;
                cnt_d   = 11'd0;
                state_d = DATA;
            end
            DATA: begin
                tx_en = 1'b1;
                if (s_valid) begin
                    byte_o = s_data;
                    crc_d  = crc_next(crc_q, s_data);
                    cnt_d  = cnt_sat;
                    if (s_last) begin
                        sub_d = 8'd0;
                        if (ENABLE_PADDING != 0 && cnt_inc < MIN_LEN)
                            state_d = PAD;
                        else
                            state_d = FCS;
                    end
                end else begin
                    tx_er = 1'b1;
                    und_d = 1'b1;
                end
            end
            PAD: begin
                tx_en = 1'b1;
                crc_d = crc_next(crc_q, 8'h00);
                cnt_d = cnt_sat;
                if (cnt_inc >= MIN_LEN) state_d = FCS;
            end
            FCS: begin
                tx_en = 1'b1;
                unique case (sub_q[1:0])
                    2'd0: byte_o = crc_inv[7:0];
                    2'd1: byte_o = crc_inv[15:8];
                    2'd2: byte_o = crc_inv[23:16];
                    default: byte_o = crc_inv[31:24];
                endcase
                if (sub_q[1:0] == 2'd3) begin
                    done_d  = 1'b1;
                    sub_d   = 8'd0;
                    state_d = GAP;
                end else begin
                    sub_d = sub_q + 8'd1;
                end
            end
            GAP: begin
                if (sub_q == GAP_LAST) state_d = IDLE;
                else                   sub_d   = sub_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase

        txd_d = {byte_o[3:0], byte_o[7:4]};
        ctl_d = {tx_en, tx_en ^ tx_er};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sub_q   <= 8'd0;
            cnt_q   <= 11'd0;
            crc_q   <= 32'd0;
            txd_q   <= 8'h00;
            ctl_q   <= 2'b00;
            done_q  <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            txd_q   <= txd_d;
            ctl_q   <= ctl_d;
            done_q  <= done_d;
            und_q   <= und_d;
        end
    end

    assign ddr_data_output = txd_q;
    assign ddr_ctl_output  = ctl_q;
    assign frame_done      = done_q;
    assign underrun        = und_q;

endmodule

// File: tb/tb_rgmii_transmit_framer.sv
// Scoreboard bench for rgmii_transmit_framer: one padded and one unpadded
// instance, expected output beats queued by a table-driven CRC model.
module tb_rgmii_transmit_framer;

    typedef struct packed {
        logic [7:0] ddr;
        logic [1:0] ctl;
        logic       done;
        logic       und;
        logic [1:0] gmode;  // 0 no gap check, 1 gap >= IFG, 2 gap == IFG
    } beat_t;

    localparam int MIN = 60;
    localparam int IFG = 12;

    logic       clock;
    logic [1:0] rst;
    logic [7:0] s_data [2];
    logic [1:0] s_valid;
    logic [1:0] s_last;
    logic [1:0] s_ready;
    logic [7:0] ddr_d [2];
    logic [1:0] ddr_c [2];
    logic [1:0] done;
    logic [1:0] und;

    int checks = 0;
    int errors = 0;

    beat_t       exp_q [2][$];
    logic [31:0] crc_tab [256];

    rgmii_transmit_framer #(
        .MIN_FRAME_BYTES(MIN), .ENABLE_PADDING(1), .IFG_BYTES(IFG)
    ) u_pad (
        .clock(clock), .reset(rst[0]),
        .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]),
        .s_ready(s_ready[0]),
        .ddr_data_output(ddr_d[0]), .ddr_ctl_output(ddr_c[0]),
        .frame_done(done[0]), .underrun(und[0])
    );

    rgmii_transmit_framer #(
        .MIN_FRAME_BYTES(MIN), .ENABLE_PADDING(0), .IFG_BYTES(IFG)
    ) u_nopad (
        .clock(clock), .reset(rst[1]),
        .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]),
        .s_ready(s_ready[1]),
        .ddr_data_output(ddr_d[1]), .ddr_ctl_output(ddr_c[1]),
        .frame_done(done[1]), .underrun(und[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitors: pop one expected beat per non-idle output cycle.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        int    idle_cnt = 0;
        bit    seen = 0;
        beat_t e;
        always @(negedge clock) begin
            if (ddr_d[g] === 8'h00 && ddr_c[g] === 2'b00 &&
                done[g] === 1'b0 && und[g] === 1'b0) begin
                idle_cnt++;
                checks++;
                if (s_ready[g] !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_ready%0d: s_ready %b, expected 0",
                             g, s_ready[g]);
                end
            end else if (exp_q[g].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected%0d: ddr %h ctl %b done %b und %b, expected idle",
                         g, ddr_d[g], ddr_c[g], done[g], und[g]);
            end else begin
                e = exp_q[g].pop_front();
                checks++;
                if (ddr_d[g] !== e.ddr || ddr_c[g] !== e.ctl ||
                    done[g] !== e.done || und[g] !== e.und) begin
                    errors++;
                    $display("FAIL beat%0d: ddr %h ctl %b done %b und %b, expected ddr %h ctl %b done %b und %b",
                             g, ddr_d[g], ddr_c[g], done[g], und[g],
                             e.ddr, e.ctl, e.done, e.und);
                end
                if (e.gmode != 2'd0 && seen) begin
                    checks++;
                    if ((e.gmode == 2'd2 && idle_cnt != IFG) ||
                        (e.gmode == 2'd1 && idle_cnt < IFG)) begin
                        errors++;
                        $display("FAIL gap%0d: %0d idle cycles, expected %s %0d",
                                 g, idle_cnt, e.gmode == 2'd2 ? "==" : ">=", IFG);
                    end
                end
                if (done[g] === 1'b1) begin
                    seen = 1;
                    idle_cnt = 0;
                end
            end
        end
    end

    task automatic push_beat(input int i, input logic [7:0] b,
                             input logic [1:0] c, input logic d,
                             input logic u, input logic [1:0] gm);
        beat_t x;
        x.ddr   = {b[3:0], b[7:4]};
        x.ctl   = c;
        x.done  = d;
        x.und   = u;
        x.gmode = gm;
        exp_q[i].push_back(x);
    endtask

    task automatic push_head(input int i, input logic [1:0] gm);
        push_beat(i, 8'h55, 2'b11, 0, 0, gm);
        repeat (6) push_beat(i, 8'h55, 2'b11, 0, 0, 2'd0);
        push_beat(i, 8'hD5, 2'b11, 0, 0, 2'd0);
    endtask

    task automatic push_body(input int i, input logic [7:0] pl[$],
                             input int st[$]);
        for (int k = 0; k < pl.size(); k++) begin
            if (k > 0) repeat (st[k]) push_beat(i, 8'h00, 2'b10, 0, 1, 2'd0);
            push_beat(i, pl[k], 2'b11, 0, 0, 2'd0);
        end
    endtask

    task automatic model_frame(input int i, input logic [7:0] pl[$],
                               input int st[$], input logic [1:0] gm,
                               input bit pad_en);
        logic [7:0]  body[$];
        logic [31:0] crc;
        body = pl;
        while (pad_en && body.size() < MIN) body.push_back(8'h00);
        crc = 32'hFFFFFFFF;
        foreach (body[k]) crc = crc_tab[(crc ^ {24'd0, body[k]}) & 32'hFF] ^ (crc >> 8);
        crc = ~crc;
        push_head(i, gm);
        push_body(i, pl, st);
        for (int k = pl.size(); k < body.size(); k++)
            push_beat(i, 8'h00, 2'b11, 0, 0, 2'd0);
        for (int k = 0; k < 4; k++)
            push_beat(i, crc[8*k +: 8], 2'b11, k == 3, 0, 2'd0);
    endtask

    task automatic xfer(input int i, input logic [7:0] b, input logic l);
        bit ok;
        s_valid[i] = 1'b1;
        s_data[i]  = b;
        s_last[i]  = l;
        for (int k = 0; k < 300; k++) begin
            ok = s_ready[i];
            @(negedge clock);
            if (ok) return;
        end
        checks++;
        errors++;
        $display("FAIL ready_timeout%0d: no s_ready within 300 cycles, expected handshake", i);
    endtask

    task automatic drive_frame(input int i, input logic [7:0] pl[$],
                               input int st[$], input bit keep);
        for (int k = 0; k < pl.size(); k++) begin
            if (k > 0) repeat (st[k]) begin
                s_valid[i] = 1'b0;
                @(negedge clock);
            end
            xfer(i, pl[k], k == pl.size() - 1);
        end
        s_last[i] = 1'b0;
        if (!keep) s_valid[i] = 1'b0;
    endtask

    task automatic rand_payload(input int n, output logic [7:0] pl[$],
                                output int st[$], input bit stalls);
        pl = {};
        st = {};
        for (int k = 0; k < n; k++) begin
            pl.push_back(8'($urandom));
            st.push_back((stalls && $urandom_range(0, 7) == 0) ?
                         int'($urandom_range(1, 3)) : 0);
        end
    endtask

    initial begin
        logic [7:0]  pl[$];
        int          st[$];
        logic [31:0] c;
        bit          keep;
        bit          prev_keep;

        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            repeat (8) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
            crc_tab[n] = c;
        end

        rst       = 2'b11;
        s_valid   = 2'b00;
        s_last    = 2'b00;
        s_data[0] = 8'h00;
        s_data[1] = 8'h00;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ddr_d[i] !== 8'h00 || ddr_c[i] !== 2'b00 ||
                s_ready[i] !== 1'b0 || done[i] !== 1'b0 || und[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state%0d: ddr %h ctl %b rdy %b done %b und %b, expected all 0",
                         i, ddr_d[i], ddr_c[i], s_ready[i], done[i], und[i]);
            end
        end
        rst = 2'b00;
        @(negedge clock);

        // "123456789" without padding, known FCS, then a back-to-back frame.
        pl = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        st = {0, 0, 0, 0, 0, 0, 0, 0, 0};
        push_head(1, 2'd0);
        push_body(1, pl, st);
        push_beat(1, 8'h26, 2'b11, 0, 0, 2'd0);
        push_beat(1, 8'h39, 2'b11, 0, 0, 2'd0);
        push_beat(1, 8'hF4, 2'b11, 0, 0, 2'd0);
        push_beat(1, 8'hCB, 2'b11, 1, 0, 2'd0);
        drive_frame(1, pl, st, 1);
        rand_payload(64, pl, st, 0);
        pl[0] = 8'hA5;
        model_frame(1, pl, st, 2'd2, 0);
        drive_frame(1, pl, st, 0);

        // 14-byte padded frame, then two back-to-back 64-byte frames.
        rand_payload(14, pl, st, 0);
        model_frame(0, pl, st, 2'd0, 1);
        drive_frame(0, pl, st, 1);
        rand_payload(64, pl, st, 0);
        model_frame(0, pl, st, 2'd2, 1);
        drive_frame(0, pl, st, 1);
        rand_payload(64, pl, st, 0);
        model_frame(0, pl, st, 2'd2, 1);
        drive_frame(0, pl, st, 0);

        // Three starved cycles mid-payload.
        rand_payload(64, pl, st, 0);
        st[20] = 3;
        model_frame(0, pl, st, 2'd1, 1);
        drive_frame(0, pl, st, 0);
        repeat (40) @(negedge clock);

        // Reset while the 5th data byte is offered.
        rand_payload(8, pl, st, 0);
        push_head(0, 2'd1);
        for (int k = 0; k < 4; k++) push_beat(0, pl[k], 2'b11, 0, 0, 2'd0);
        for (int k = 0; k < 4; k++) xfer(0, pl[k], 1'b0);
        s_data[0] = pl[4];
        rst[0]    = 1'b1;
        @(negedge clock);
        checks++;
        if (ddr_d[0] !== 8'h00 || ddr_c[0] !== 2'b00 || s_ready[0] !== 1'b0 ||
            done[0] !== 1'b0 || und[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: ddr %h ctl %b rdy %b done %b und %b, expected all 0",
                     ddr_d[0], ddr_c[0], s_ready[0], done[0], und[0]);
        end
        rst[0]     = 1'b0;
        s_valid[0] = 1'b0;
        repeat (5) @(negedge clock);
        rand_payload(20, pl, st, 0);
        model_frame(0, pl, st, 2'd0, 1);
        drive_frame(0, pl, st, 0);

        // Randomized frames with stalls and mixed back-to-back spacing.
        prev_keep = 0;
        for (int f = 0; f < 24; f++) begin
            rand_payload($urandom_range(1, 100), pl, st, 1);
            keep = ($urandom_range(0, 2) == 0);
            model_frame(0, pl, st, prev_keep ? 2'd2 : 2'd1, 1);
            drive_frame(0, pl, st, keep);
            if (!keep) repeat ($urandom_range(0, 20)) @(negedge clock);
            prev_keep = keep;
        end

        // Frame longer than the counter range.
        rand_payload(2100, pl, st, 0);
        model_frame(0, pl, st, prev_keep ? 2'd2 : 2'd1, 1);
        drive_frame(0, pl, st, 0);

        for (int k = 0; k < 5000; k++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
            @(negedge clock);
        end
        repeat (20) @(negedge clock);
        checks++;
        if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d beats outstanding, expected 0/0",
                     exp_q[0].size(), exp_q[1].size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
